multdiv_seq_ctrl: RTL and testbench
===================================

// Module: multdiv_seq_ctrl
// PURPOSE
//  Sequencer between the single-cycle decode/control logic and the multicycle multdiv unit.
//  Detects R-type mul/div, pulses the unit's start strobe and stalls PC/regfile until the result is ready.
//  Then issues one write-back: rd on success, or $r30 (rstatus) with an exception code on error/timeout.
//  Sits beside the combinational control decoder in the processor top level.
// PARAMETERS
//  DATA_WIDTH    32  width of md_result / wb_data
//  TIMEOUT       40  max BUSY cycles before forced exception; >=2
//  MUL_EXC_CODE  4   rstatus value written on mul exception/timeout
//  DIV_EXC_CODE  5   rstatus value written on div exception/timeout
// PORTS
//  clock         in   1   single clock, rising edge
//  reset         in   1   asynchronous, active-high
//  inst_valid    in   1   decoded instruction present this cycle
//  opcode        in   5   instr[31:27]
//  alu_op        in   5   instr[6:2]; mul=00110, div=00111
//  md_ready      in   1   multdiv data_resultRDY
//  md_exception  in   1   multdiv data_exception, valid with md_ready
//  md_result     in   DW  multdiv data_result, valid with md_ready
//  ctrl_mult     out  1   one-cycle start strobe, multiply
//  ctrl_div      out  1   one-cycle start strobe, divide
//  stall         out  1   hold PC and suppress normal regfile write
//  wb_en         out  1   write-back strobe, one cycle
//  wb_rstatus    out  1   1: write target is $r30; 0: write target is rd
//  wb_data       out  DW  write-back data
// BEHAVIOUR
//  is_md = inst_valid & opcode==00000 & (alu_op==00110 | alu_op==00111).
//  States: IDLE, START, BUSY, DONE. Reset -> IDLE, counter=0, op_is_div=0, result/exc regs=0.
//  All outputs are 0 during reset.
//  IDLE:  stall = is_md (combinational); ctrl/wb outputs 0.
//         is_md -> START, latch op_is_div = alu_op[0]; else stay IDLE.
//  START: ctrl_mult = ~op_is_div, ctrl_div = op_is_div (Moore, exactly one cycle); stall=1.
//         md_ready ignored. Clear counter -> BUSY.
//  BUSY:  stall=1; counter++ per cycle.
//         md_ready -> DONE, capture md_result and md_exception.
//         Else if counter==TIMEOUT-1 -> DONE with exception forced to 1.
//         md_ready wins over timeout in the same cycle.
//         inst_valid/opcode changes are ignored; the op is committed.
//  DONE:  stall=0, wb_en=1.
//         No exception: wb_rstatus=0, wb_data=result.
//         Exception: wb_rstatus=1, wb_data=op_is_div ? DIV_EXC_CODE : MUL_EXC_CODE (zero-extended).
//         Unconditional -> IDLE. PC advances at end of DONE, so is_md is not re-detected in DONE.
//  Latency: detect cycle + START + k BUSY cycles + DONE; minimum 4 cycles, k>=1.
//  Back-to-back mul/div: the next is_md is seen in the IDLE cycle after DONE; no lost instruction.
//  Non-md instructions in IDLE: stall=0, zero added latency.
//  Reset mid-operation: async return to IDLE, strobes drop immediately, no write-back issued.
//  The counter saturates at TIMEOUT-1 and never wraps.
// STRUCTURE
//  Shared header multdiv_ctrl_defs.vh holds:
//   - state encodings (2-bit)
//   - OPC_RTYPE, ALUOP_MUL, ALUOP_DIV constants
//   - RSTATUS_REG=30
//  Sub-module md_timeout_counter: clear, enable, count, hit flag at TIMEOUT-1.
//  FSM and write-back mux stay in this module.
// TESTING
//  1 mul, md_ready 3 cycles after START, result 0x0000002A
//    -> ctrl_mult pulses once; stall high 5 cycles; wb_en=1, wb_rstatus=0, wb_data=0x2A.
//  2 div, md_ready with md_exception=1 (divide by zero)
//    -> wb_rstatus=1, wb_data=5, ctrl_div was the only strobe.
//  3 mul, md_ready never asserted, TIMEOUT=40
//    -> DONE 40 cycles after START; wb_rstatus=1, wb_data=4.
//  4 md_ready asserted in START, then again 2 cycles later
//    -> START-cycle ready ignored; second ready captured.
//  5 add, then mul, then div back-to-back
//    -> add never stalls; each md op gets exactly one strobe and one wb_en; no write-back overlap.
//  6 reset asserted mid-BUSY
//    -> all outputs 0 immediately, state IDLE; next mul runs normally.

Source files
------------

// File: rtl/multdiv_seq_ctrl_pkg.sv
// rtl/multdiv_seq_ctrl_pkg.sv - shared states, decode constants and md-op detect for the multdiv sequencer
package multdiv_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } md_state_e;

    localparam logic [4:0] OPC_RTYPE   = 5'b00000;
    localparam logic [4:0] ALUOP_MUL   = 5'b00110;
    localparam logic [4:0] ALUOP_DIV   = 5'b00111;
    localparam int         RSTATUS_REG = 30;

    function automatic logic is_md_op(input logic valid, input logic [4:0] opcode,
                                      input logic [4:0] alu_op);
        return valid && (opcode == OPC_RTYPE) &&
               ((alu_op == ALUOP_MUL) || (alu_op == ALUOP_DIV));
    endfunction

endpackage

// File: rtl/multdiv_seq_ctrl_if.sv
// rtl/multdiv_seq_ctrl_if.sv - decode, multdiv and write-back signals between core and sequencer
interface multdiv_seq_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  inst_valid;
    logic [4:0]            opcode;
    logic [4:0]            alu_op;
    logic                  md_ready;
    logic                  md_exception;
    logic [DATA_WIDTH-1:0] md_result;
    logic                  ctrl_mult;
    logic                  ctrl_div;
    logic                  stall;
    logic                  wb_en;
    logic                  wb_rstatus;
    logic [DATA_WIDTH-1:0] wb_data;

    modport master (
        output inst_valid, opcode, alu_op, md_ready, md_exception, md_result,
        input  ctrl_mult, ctrl_div, stall, wb_en, wb_rstatus, wb_data
    );

    modport slave (
        input  inst_valid, opcode, alu_op, md_ready, md_exception, md_result,
        output ctrl_mult, ctrl_div, stall, wb_en, wb_rstatus, wb_data
    );
endinterface

// File: rtl/multdiv_seq_ctrl_timeout.sv
// rtl/multdiv_seq_ctrl_timeout.sv - saturating busy-cycle counter flagging the last allowed cycle
module multdiv_seq_ctrl_timeout #(
    parameter int TIMEOUT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);
    localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    assign hit = (count == LAST);

    // Holds at LAST so a late md_ready can never see a wrapped count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !hit) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multdiv_seq_ctrl.sv
// rtl/multdiv_seq_ctrl.sv - stalls the core around a multicycle mul/div and issues its single write-back
module multdiv_seq_ctrl
    import multdiv_seq_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int TIMEOUT      = 40,
    parameter int MUL_EXC_CODE = 4,
    parameter int DIV_EXC_CODE = 5
) (
    input logic            clock,
    input logic            reset,
    multdiv_seq_ctrl_if.slave bus
);
    md_state_e             state;
    logic                  op_is_div;
    logic                  stall_q;
    logic                  ctrl_mult_q;
    logic                  ctrl_div_q;
    logic                  wb_en_q;
    logic                  wb_rstatus_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic                  is_md;
    logic                  to_hit;
    logic [DATA_WIDTH-1:0] exc_word;

    assign is_md    = is_md_op(bus.inst_valid, bus.opcode, bus.alu_op);
    assign exc_word = op_is_div ? DATA_WIDTH'(DIV_EXC_CODE) : DATA_WIDTH'(MUL_EXC_CODE);

    multdiv_seq_ctrl_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (state == ST_START),
        .enable (state == ST_BUSY),
        .hit    (to_hit)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            op_is_div    <= 1'b0;
            stall_q      <= 1'b0;
            ctrl_mult_q  <= 1'b0;
            ctrl_div_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            wb_rstatus_q <= 1'b0;
            wb_data_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (is_md) begin
                        state       <= ST_START;
                        op_is_div   <= bus.alu_op[0];
                        ctrl_mult_q <= ~bus.alu_op[0];
                        ctrl_div_q  <= bus.alu_op[0];
                        stall_q     <= 1'b1;
                    end
                end
                ST_START: begin
                    ctrl_mult_q <= 1'b0;
                    ctrl_div_q  <= 1'b0;
                    state       <= ST_BUSY;
                end
                ST_BUSY: begin
                    // A genuine ready on the final counted cycle beats the timeout.
                    if (bus.md_ready || to_hit) begin
                        state   <= ST_DONE;
                        stall_q <= 1'b0;
                        wb_en_q <= 1'b1;
                        if (bus.md_ready && !bus.md_exception) begin
                            wb_rstatus_q <= 1'b0;
                            wb_data_q    <= bus.md_result;
                        end else begin
                            wb_rstatus_q <= 1'b1;
                            wb_data_q    <= exc_word;
                        end
                    end
                end
                ST_DONE: begin
                    wb_en_q      <= 1'b0;
                    wb_rstatus_q <= 1'b0;
                    wb_data_q    <= '0;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Detect-cycle stall is combinational so the PC holds on the same cycle the op is seen.
    assign bus.stall      = stall_q | ((state == ST_IDLE) && is_md && !reset);
    assign bus.ctrl_mult  = ctrl_mult_q;
    assign bus.ctrl_div   = ctrl_div_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_rstatus = wb_rstatus_q;
    assign bus.wb_data    = wb_data_q;

endmodule

// File: tb/tb_multdiv_seq_ctrl.sv
// tb/tb_multdiv_seq_ctrl.sv - directed scoreboard bench for the multdiv sequencer
module tb_multdiv_seq_ctrl;
    localparam int TO = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multdiv_seq_ctrl_if #(.DATA_WIDTH(32)) bus();

    multdiv_seq_ctrl #(
        .DATA_WIDTH   (32),
        .TIMEOUT      (TO),
        .MUL_EXC_CODE (4),
        .DIV_EXC_CODE (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        rstatus;
        logic [31:0] data;
    } wb_t;

    wb_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  n_mult = 0, n_div = 0, n_wb = 0, n_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] opc, input logic [4:0] aop,
                         input logic rdy, input logic exc, input logic [31:0] res);
        bus.inst_valid   = v;
        bus.opcode       = opc;
        bus.alu_op       = aop;
        bus.md_ready     = rdy;
        bus.md_exception = exc;
        bus.md_result    = res;
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.ctrl_mult) n_mult++;
            if (bus.ctrl_div)  n_div++;
            if (bus.stall)     n_stall++;
            if (bus.wb_en) begin
                wb_t e;
                n_wb++;
                chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
                chk("wb_stall_overlap", 32'(bus.stall), 32'd0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wb_rstatus", 32'(bus.wb_rstatus), 32'(e.rstatus));
                    chk("wb_data", bus.wb_data, e.data);
                end
            end
        end
    end

    // rdy_at: BUSY cycle (1-based) carrying md_ready, 0 = never ready.
    task automatic do_md(input logic is_div, input int rdy_at, input logic exc,
                         input logic [31:0] res, input logic early, input string tag);
        int         m0, d0, w0, s0, cyc, exp_lat;
        logic [4:0] aop;
        wb_t        e;
        m0 = n_mult; d0 = n_div; w0 = n_wb; s0 = n_stall;
        aop = is_div ? 5'b00111 : 5'b00110;
        e.rstatus = exc || (rdy_at == 0);
        e.data    = e.rstatus ? (is_div ? 32'd5 : 32'd4) : res;
        exp_q.push_back(e);
        exp_lat = (rdy_at == 0) ? TO + 1 : rdy_at + 1;

        @(posedge clock); #1 drive(1'b1, 5'b00000, aop, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk({tag, "_detect_stall"}, 32'(bus.stall), 32'd1);

        @(posedge clock); #1 drive(1'b1, 5'b00000, aop, early, early, 32'hDEAD_BEEF);
        @(negedge clock);
        chk({tag, "_strobe"}, 32'({bus.ctrl_mult, bus.ctrl_div}), is_div ? 32'd1 : 32'd2);

        cyc = 0;
        while (cyc < TO + 5) begin
            cyc++;
            @(posedge clock);
            #1 drive(1'b1, 5'b00000, aop, cyc == rdy_at, exc && (cyc == rdy_at),
                     (cyc == rdy_at) ? res : 32'hBAD0_0000 + 32'(cyc));
            @(negedge clock);
            if (bus.wb_en) break;
        end
        #1;
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_stall_cycles"}, 32'(n_stall - s0), 32'(exp_lat + 1));
        chk({tag, "_mult_strobes"}, 32'(n_mult - m0), is_div ? 32'd0 : 32'd1);
        chk({tag, "_div_strobes"}, 32'(n_div - d0), is_div ? 32'd1 : 32'd0);
        chk({tag, "_wb_count"}, 32'(n_wb - w0), 32'd1);
    endtask

    task automatic idle_check(input string tag);
        @(posedge clock); #1 drive(1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk({tag, "_idle"}, 32'({bus.stall, bus.ctrl_mult, bus.ctrl_div, bus.wb_en}), 32'd0);
    endtask

    initial begin
        int w0;
        drive(1'b1, 5'b00000, 5'b00110, 1'b0, 1'b0, 32'h0);
        #2;
        chk("reset_outputs", 32'({bus.stall, bus.ctrl_mult, bus.ctrl_div, bus.wb_en, bus.wb_rstatus}), 32'd0);
        chk("reset_wb_data", bus.wb_data, 32'd0);
        @(negedge clock);
        drive(1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'h0);
        #1 reset = 1'b0;
        idle_check("post_reset");

        do_md(1'b0, 3, 1'b0, 32'h0000_002A, 1'b0, "t1_mul");
        do_md(1'b1, 2, 1'b1, 32'h0000_0000, 1'b0, "t2_div0");
        do_md(1'b0, 0, 1'b0, 32'h0000_0000, 1'b0, "t3_timeout");
        do_md(1'b1, TO, 1'b0, 32'h0000_CAFE, 1'b0, "t3_ready_wins");
        do_md(1'b0, 2, 1'b0, 32'h1234_5678, 1'b1, "t4_early_ready");
        do_md(1'b0, 4, 1'b1, 32'h0000_0055, 1'b0, "t4_mul_exc");
        idle_check("t4");

        // add, then mul, then div with no gaps
        @(posedge clock); #1 drive(1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("t5_add_no_stall", 32'({bus.stall, bus.ctrl_mult, bus.ctrl_div}), 32'd0);
        do_md(1'b0, 1, 1'b0, 32'h0000_0007, 1'b0, "t5_mul");
        do_md(1'b1, 5, 1'b0, 32'h0000_0003, 1'b0, "t5_div");
        @(posedge clock); #1 drive(1'b1, 5'b00101, 5'b00110, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        chk("t5_non_rtype", 32'({bus.stall, bus.ctrl_mult, bus.ctrl_div}), 32'd0);
        idle_check("t5");

        // reset in the second BUSY cycle
        w0 = n_wb;
        @(posedge clock); #1 drive(1'b1, 5'b00000, 5'b00110, 1'b0, 1'b0, 32'h0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        #1;
        chk("t6_outputs", 32'({bus.stall, bus.ctrl_mult, bus.ctrl_div, bus.wb_en, bus.wb_rstatus}), 32'd0);
        chk("t6_wb_data", bus.wb_data, 32'd0);
        chk("t6_state", 32'(dut.state), 32'd0);
        @(negedge clock);
        drive(1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 32'h0);
        #1 reset = 1'b0;
        repeat (3) idle_check("t6_after");
        chk("t6_no_wb", 32'(n_wb - w0), 32'd0);
        do_md(1'b0, 2, 1'b0, 32'h0000_0099, 1'b0, "t6_mul");
        idle_check("end");
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
